// File: rtl/voice_slot_scheduler.sv
// voice_slot_scheduler: round-robin time-sharing of one tone engine among N_REQ key request lines
// Each winner holds the engine for SLOT_CYCLES cycles, or until its key is released.
module voice_slot_scheduler #(
    parameter int N_REQ       = 10,
    parameter int IDX_W       = 4,
    parameter int SLOT_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             eng_ready,
    output logic             eng_valid,
    output logic [IDX_W-1:0] note_idx,
    output logic [N_REQ-1:0] grant,
    output logic             slot_end,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;
    localparam logic [IDX_W:0]   NR   = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ-1);
    state_t           state;
    logic [IDX_W-1:0] ptr, off, win;
    logic [IDX_W:0]   sum;
    logic [N_REQ-1:0] rot;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    // rotate req so bit ptr lands at position 0, then take the first set bit
    assign rot = N_REQ'({req, req} >> ptr);
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = IDX_W'(i);
            end
        end
    end
    assign sum      = {1'b0, ptr} + {1'b0, off};
    assign win      = sum >= NR ? IDX_W'(sum - NR) : IDX_W'(sum);
    assign slot_end = (state == PLAY) && (cnt == '0 || !req[note_idx]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            eng_valid <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            note_idx  <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    grant     <= N_REQ'(1) << win;
                    note_idx  <= win;
                    eng_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (eng_ready) begin
                    eng_valid <= 1'b0;
                    cnt       <= CNT_W'(SLOT_CYCLES-1);
                    state     <= PLAY;
                end
                PLAY: if (slot_end) begin
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= note_idx == LAST ? '0 : note_idx + 1'b1;
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_slot_scheduler.sv
// tb_voice_slot_scheduler: directed scenarios for the round-robin voice slot scheduler
// Inputs are driven and outputs sampled just after each falling edge.
module tb_voice_slot_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req = '0;
    logic       eng_ready = 1'b1;
    logic       eng_valid, slot_end, busy;
    logic [3:0] note_idx;
    logic [9:0] grant;
    int errors = 0;
    int checks = 0;

    voice_slot_scheduler #(.N_REQ(10), .IDX_W(4), .SLOT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .eng_ready(eng_ready), .eng_valid(eng_valid),
        .note_idx(note_idx), .grant(grant), .slot_end(slot_end), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b want 0", busy); end
    endtask

    task automatic wait_grant(input logic [3:0] k, input string name);
        logic [9:0] eg;
        eg = 10'd1 << k;
        for (int i = 0; i < 20; i++) begin
            step();
            if (eng_valid) break;
        end
        checks++;
        if (eng_valid !== 1'b1 || note_idx !== k || grant !== eg) begin
            errors++;
            $display("FAIL %s: valid=%b idx=%0d grant=%h want valid=1 idx=%0d grant=%h", name, eng_valid, note_idx, grant, k, eg);
        end
    endtask

    task automatic test_reset();
        req = 10'h3FF;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({eng_valid, grant, slot_end, busy, note_idx} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b grant=%h end=%b busy=%b idx=%0d want all 0", eng_valid, grant, slot_end, busy, note_idx);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 10'h001 || note_idx !== 4'd0 || eng_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%h idx=%0d valid=%b busy=%b want 001 0 1 1", grant, note_idx, eng_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] eg;
        int ends;
        for (int s = 0; s < 10; s++) begin
            ends = 0;
            for (int c = 0; c < 6; c++) begin
                eg = (c == 5) ? 10'h000 : (10'd1 << s);
                checks++;
                if (grant !== eg || eng_valid !== (c == 0) || slot_end !== (c == 4) || busy !== (c != 5)
                    || (c != 5 && note_idx !== 4'(s))) begin
                    errors++;
                    $display("FAIL rr_key%0d_cyc%0d: grant=%h valid=%b end=%b busy=%b idx=%0d want grant=%h valid=%b end=%b",
                             s, c, grant, eng_valid, slot_end, busy, note_idx, eg, c == 0, c == 4);
                end
                if (slot_end) ends++;
                step();
            end
            checks++;
            if (ends != 1) begin errors++; $display("FAIL rr_slot_end_count key%0d: got %0d want 1", s, ends); end
        end
        checks++;
        if (grant !== 10'h001 || note_idx !== 4'd0 || eng_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_wrap: grant=%h idx=%0d want 001 0", grant, note_idx);
        end
    endtask

    task automatic test_ptr_skip();
        do_reset();
        req = 10'h004;
        wait_grant(4'd2, "skip_first2");
        wait_idle();
        req = 10'h204;
        wait_grant(4'd9, "skip_9_before_2");
        wait_idle();
        wait_grant(4'd2, "skip_then_2");
        wait_idle();
        wait_grant(4'd9, "skip_then_9");
    endtask

    task automatic test_backpressure();
        wait_idle();
        eng_ready = 1'b0;
        wait_grant(4'd2, "bp_grant");
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (eng_valid !== 1'b1 || note_idx !== 4'd2 || grant !== 10'h004 || slot_end !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b idx=%0d grant=%h end=%b want 1 2 004 0", c, eng_valid, note_idx, grant, slot_end);
            end
        end
        eng_ready = 1'b1;
        step();
        checks++;
        if (eng_valid !== 1'b0 || grant !== 10'h004 || busy !== 1'b1 || slot_end !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: valid=%b grant=%h busy=%b end=%b want 0 004 1 0", eng_valid, grant, busy, slot_end);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 10'h020;
        wait_grant(4'd5, "early_grant5");
        step();
        checks++;
        if (slot_end !== 1'b0 || grant !== 10'h020) begin
            errors++;
            $display("FAIL early_play1: end=%b grant=%h want 0 020", slot_end, grant);
        end
        step();
        req = 10'h3DF;
        #1;
        checks++;
        if (slot_end !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_slot_end: end=%b busy=%b want 1 1", slot_end, busy);
        end
        step();
        checks++;
        if (grant !== 10'h000 || busy !== 1'b0 || slot_end !== 1'b0) begin
            errors++;
            $display("FAIL early_release: grant=%h busy=%b end=%b want 000 0 0", grant, busy, slot_end);
        end
        wait_grant(4'd6, "early_next_from_ptr6");
    endtask

    task automatic test_reset_mid_play();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 10'h000 || busy !== 1'b0 || slot_end !== 1'b0 || eng_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset: grant=%h busy=%b end=%b valid=%b want 000 0 0 0", grant, busy, slot_end, eng_valid);
        end
        req = 10'h010;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 10'h010 || note_idx !== 4'd4 || eng_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_regrant: grant=%h idx=%0d valid=%b want 010 4 1", grant, note_idx, eng_valid);
        end
    endtask

    task automatic test_idle_no_req();
        do_reset();
        req = 10'h000;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || grant !== 10'h000 || eng_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b grant=%h valid=%b want 0 000 0", busy, grant, eng_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ptr_skip();
        test_backpressure();
        test_early_release();
        test_reset_mid_play();
        test_idle_no_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
